preview_record_reader: RTL

- Downstream consumer of the dual-port preview FIFO.
- Decodes a stream of 1-word (short) and 2-word (long) records from the FIFO's show-ahead outputs and issues the matching one-hot 0/1/2-word read request.
- Delivers whole records through a 2-entry output buffer with a valid/ready handshake.
- Provides per-type record counters, a stall watchdog and a discard-flush mode.

---
 rtl/preview_record_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/preview_record_reader.sv
// rtl/preview_record_reader.sv - decodes short/long records from a show-ahead FIFO into a 2-entry output buffer
module preview_record_reader #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 255
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [1:0]       f_empty,
    input  logic [WIDTH-1:0] f_od0,
    input  logic [WIDTH-1:0] f_od1,
    output logic [2:0]       f_rdreq,
    input  logic             flush,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic             rec_long,
    output logic [WIDTH-1:0] rec_w0,
    output logic [WIDTH-1:0] rec_w1,
    output logic [CNT_W-1:0] short_cnt,
    output logic [CNT_W-1:0] long_cnt,
    output logic             err_stall
);

    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [1:0]       occ;
    logic             tail_long;
    logic [WIDTH-1:0] tail_w0;
    logic [WIDTH-1:0] tail_w1;
    logic [SW-1:0]    stall_cnt;

    logic             avail1;
    logic             avail2;
    logic             hdr_long;
    logic             push;
    logic             push_long;
    logic [WIDTH-1:0] new_w1;
    logic             pop;
    logic             stall_cond;

    assign avail1    = ~&f_empty;
    assign avail2    = ~|f_empty;
    assign hdr_long  = f_od0[WIDTH-1];
    assign rec_valid = (occ != 2'd0);
    assign pop       = rec_valid & rec_ready;
    assign new_w1    = push_long ? f_od1 : '0;

    // Read decisions depend only on registered occupancy and FIFO flags, never on rec_ready.
    always_comb begin
        f_rdreq   = 3'b001;
        push      = 1'b0;
        push_long = 1'b0;
        if (nrst) begin
            if (flush) begin
                if (avail2)
                    f_rdreq = 3'b100;
                else if (avail1)
                    f_rdreq = 3'b010;
            end else if (occ < 2'd2) begin
                if (!hdr_long && avail1) begin
                    f_rdreq = 3'b010;
                    push    = 1'b1;
                end else if (hdr_long && avail2) begin
                    f_rdreq   = 3'b100;
                    push      = 1'b1;
                    push_long = 1'b1;
                end
            end
        end
    end

    assign stall_cond = !flush && (occ < 2'd2) && hdr_long && avail1 && !avail2;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            occ       <= 2'd0;
            rec_long  <= 1'b0;
            rec_w0    <= '0;
            rec_w1    <= '0;
            tail_long <= 1'b0;
            tail_w0   <= '0;
            tail_w1   <= '0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        rec_long <= push_long;
                        rec_w0   <= f_od0;
                        rec_w1   <= new_w1;
                        occ      <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        rec_long <= push_long;
                        rec_w0   <= f_od0;
                        rec_w1   <= new_w1;
                    end else if (push) begin
                        tail_long <= push_long;
                        tail_w0   <= f_od0;
                        tail_w1   <= new_w1;
                        occ       <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                2'd2: begin
                    // push is gated off at occupancy 2, so only a pop can happen here
                    if (pop) begin
                        rec_long <= tail_long;
                        rec_w0   <= tail_w0;
                        rec_w1   <= tail_w1;
                        occ      <= 2'd1;
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            short_cnt <= '0;
            long_cnt  <= '0;
        end else if (push) begin
            if (push_long) begin
                if (long_cnt != {CNT_W{1'b1}})
                    long_cnt <= long_cnt + 1'b1;
            end else begin
                if (short_cnt != {CNT_W{1'b1}})
                    short_cnt <= short_cnt + 1'b1;
            end
        end
    end

    // err_stall rises on the edge where the run of stalled cycles reaches STALL_LIMIT.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_cnt <= '0;
            err_stall <= 1'b0;
        end else if (stall_cond) begin
            if (stall_cnt != SW'(STALL_LIMIT))
                stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= SW'(STALL_LIMIT - 1))
                err_stall <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule
